// File: rtl/alu_muldiv_if.sv
// Bus bundle for alu_muldiv: EX-stage operands/opcode in, start/busy/done
// handshake, and the registered result, Zero flag and HI/LO registers out.
interface alu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] entradaA;
  logic [WIDTH-1:0] entradaB;
  logic [3:0]       entradaControl;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ALUresult;
  logic             Zero;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  // Control unit / pipeline side: drives the operation, watches the handshake.
  modport master (
    output start, entradaA, entradaB, entradaControl,
    input  busy, done, ALUresult, Zero, HI, LO
  );

  // ALU side.
  modport slave (
    input  start, entradaA, entradaB, entradaControl,
    output busy, done, ALUresult, Zero, HI, LO
  );
endinterface

// File: rtl/alu_muldiv.sv
// Multi-cycle ALU with iterative multiply/divide into internal HI/LO.
//   - 1-cycle MIPS logic/arithmetic ops: result registered at the start edge.
//   - MULTU: shift-add, one multiplier bit per cycle.
//   - DIVU : restoring division, one quotient bit per cycle.
//   - MFHI/MFLO read back the HI/LO registers.
// Optional feature macro: MULDIV_SIGNED_EN adds signed MULT (10) and DIV (11);
// operands are converted to magnitudes on launch and the result is sign-fixed
// on completion. Without it, opcodes 10/11 behave as illegal opcodes.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic        clk,
  input logic        rst_n,
  alu_muldiv_if.slave bus
);

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_MULTU = 4'd8;
  localparam logic [3:0] OP_DIVU  = 4'd9;
  localparam logic [3:0] OP_NOR   = 4'd12;
  localparam logic [3:0] OP_MFHI  = 4'd13;
  localparam logic [3:0] OP_MFLO  = 4'd14;
`ifdef MULDIV_SIGNED_EN
  localparam logic [3:0] OP_MULT  = 4'd10;
  localparam logic [3:0] OP_DIV   = 4'd11;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Architectural outputs
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  // Iteration working registers: acc_hi/acc_lo hold the partial product
  // (multiply) or partial remainder/quotient (divide); op_b holds the
  // multiplicand or divisor magnitude.
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] op_b;
  logic [CNT_W-1:0] cnt;

`ifdef MULDIV_SIGNED_EN
  logic             op_signed;
  logic             neg_prod_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
`endif

  logic             busy;
  logic             can_accept;
  logic             is_mul;
  logic             is_div;
  logic             last_iter;
  logic             div_by_zero;
  logic             finishing;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] mul_hi_nxt;
  logic [WIDTH-1:0] mul_lo_nxt;
  logic [WIDTH-1:0] div_hi_nxt;
  logic [WIDTH-1:0] div_lo_nxt;
  logic [WIDTH-1:0] fin_hi;
  logic [WIDTH-1:0] fin_lo;

  assign busy        = (state == MUL) || (state == DIV);
  // FIN is the done cycle; a new op may launch there with no bubble.
  assign can_accept  = (state == IDLE) || (state == FIN);
  assign last_iter   = (cnt == CNT_W'(WIDTH - 1));
  assign div_by_zero = (op_b == '0);
  assign finishing   = ((state == MUL) && last_iter) ||
                       ((state == DIV) && (last_iter || div_by_zero));

  assign bus.busy      = busy;
  assign bus.done      = done_q;
  assign bus.ALUresult = result_q;
  assign bus.Zero      = zero_q;
  assign bus.HI        = hi_q;
  assign bus.LO        = lo_q;

  // Opcode classification and launch-time operand magnitudes.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    is_mul = (bus.entradaControl == OP_MULTU);
    is_div = (bus.entradaControl == OP_DIVU);
    a_mag  = bus.entradaA;
    b_mag  = bus.entradaB;
`ifdef MULDIV_SIGNED_EN
    op_signed = 1'b0;
    if (bus.entradaControl == OP_MULT) begin
      is_mul    = 1'b1;
      op_signed = 1'b1;
    end
    if (bus.entradaControl == OP_DIV) begin
      is_div    = 1'b1;
      op_signed = 1'b1;
    end
    if (op_signed && bus.entradaA[WIDTH-1]) a_mag = -bus.entradaA;
    if (op_signed && bus.entradaB[WIDTH-1]) b_mag = -bus.entradaB;
`endif
  end

  // Single-cycle result; illegal opcodes (and the long ops) produce 0.
  always_comb begin
    alu_res = '0;
    case (bus.entradaControl)
      OP_AND:  alu_res = bus.entradaA & bus.entradaB;
      OP_OR:   alu_res = bus.entradaA | bus.entradaB;
      OP_ADD:  alu_res = bus.entradaA + bus.entradaB;
      OP_SUB:  alu_res = bus.entradaA - bus.entradaB;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                          ($signed(bus.entradaA) < $signed(bus.entradaB))};
      OP_NOR:  alu_res = ~(bus.entradaA | bus.entradaB);
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // One shift-add multiply step and one restoring divide step.
  always_comb begin
    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit (LSB of acc_lo) is set, then shift the pair right.
    mul_sum = {1'b0, acc_hi} + {1'b0, op_b};
    if (acc_lo[0]) begin
      {mul_hi_nxt, mul_lo_nxt} = {mul_sum, acc_lo[WIDTH-1:1]};
    end else begin
      {mul_hi_nxt, mul_lo_nxt} = {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
    end

    // Divide: shift next dividend bit into the remainder, try subtracting
    // the divisor, keep the difference only if it did not go negative.
    div_trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, op_b};
    if (!div_trial[WIDTH]) begin
      div_hi_nxt = div_trial[WIDTH-1:0];
    end else begin
      div_hi_nxt = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
    end
    div_lo_nxt = {acc_lo[WIDTH-2:0], ~div_trial[WIDTH]};
  end

  // Final HI/LO values written on the edge that enters FIN.
  always_comb begin
    if (state == MUL) begin
      fin_hi = mul_hi_nxt;
      fin_lo = mul_lo_nxt;
    end else if (div_by_zero) begin
      // Divide by zero: quotient saturates to all ones, remainder = dividend.
      fin_hi = acc_lo;
      fin_lo = '1;
    end else begin
      fin_hi = div_hi_nxt;
      fin_lo = div_lo_nxt;
    end
`ifdef MULDIV_SIGNED_EN
    if (state == MUL) begin
      if (neg_prod_q) {fin_hi, fin_lo} = -{fin_hi, fin_lo};
    end else begin
      // Remainder follows the dividend sign; negating the dividend magnitude
      // also restores the raw dividend for the divide-by-zero case.
      if (neg_rem_q) fin_hi = -fin_hi;
      if (neg_quo_q && !div_by_zero) fin_lo = -fin_lo;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FIN: begin
        state_nxt = IDLE;
        if (bus.start) begin
          if (is_mul)      state_nxt = MUL;
          else if (is_div) state_nxt = DIV;
        end
      end
      MUL:     if (finishing) state_nxt = FIN;
      DIV:     if (finishing) state_nxt = FIN;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: launch, iterate, complete; done is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the iteration registers are reset along with the outputs so an aborted op leaves no stale state behind.
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      op_b     <= '0;
      cnt      <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_prod_q <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (can_accept && bus.start) begin
        if (is_mul || is_div) begin
          acc_hi <= '0;
          acc_lo <= is_mul ? b_mag : a_mag;
          op_b   <= is_mul ? a_mag : b_mag;
          cnt    <= '0;
`ifdef MULDIV_SIGNED_EN
          neg_prod_q <= op_signed && (bus.entradaA[WIDTH-1] ^ bus.entradaB[WIDTH-1]);
          neg_quo_q  <= op_signed && (bus.entradaA[WIDTH-1] ^ bus.entradaB[WIDTH-1]);
          neg_rem_q  <= op_signed && bus.entradaA[WIDTH-1];
`endif
        end else begin
          result_q <= alu_res;
          zero_q   <= (alu_res == '0);
          done_q   <= 1'b1;
        end
      end else if (finishing) begin
        hi_q     <= fin_hi;
        lo_q     <= fin_lo;
        result_q <= fin_lo;
        zero_q   <= (fin_lo == '0);
        done_q   <= 1'b1;
      end else if (busy) begin
        if (state == MUL) begin
          acc_hi <= mul_hi_nxt;
          acc_lo <= mul_lo_nxt;
        end else begin
          acc_hi <= div_hi_nxt;
          acc_lo <= div_lo_nxt;
        end
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv (WIDTH=32): the driver pushes the
// hand-computed response and the done cycle it must appear in; a monitor pops
// and compares on every done pulse. Signed vectors follow MULDIV_SIGNED_EN.
module tb_alu_muldiv;

  localparam int W = 32;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   vectors;
  int   miscompares;
  exp_t sb[$];

  alu_muldiv_if #(.WIDTH(W)) bus ();

  alu_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'(bus.done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_res"},  bus.ALUresult,  e.res);
        check({e.name, "_zero"}, 32'(bus.Zero),  32'(e.res == 32'd0));
        check({e.name, "_hi"},   bus.HI,         e.hi);
        check({e.name, "_lo"},   bus.LO,         e.lo);
        check({e.name, "_lat"},  32'(cyc),       32'(e.due));
      end
    end
  end

  // Drive one op across a start edge; inputs are scrambled afterwards so the
  // DUT must rely on its latched copies.
  task automatic issue(input string name, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [31:0] hi,
                       input logic [31:0] lo, input int lat);
    exp_t e;
    bus.entradaControl = op;
    bus.entradaA       = a;
    bus.entradaB       = b;
    bus.start          = 1'b1;
    @(posedge clk);
    #1;
    e.name = name; e.res = res; e.hi = hi; e.lo = lo; e.due = cyc + lat - 1;
    sb.push_back(e);
    bus.start    = 1'b0;
    bus.entradaA = 32'hDEAD_BEEF;
    bus.entradaB = 32'h0BAD_F00D;
  endtask

  // Returns at the negedge where done is seen, so the next issue lands in the
  // done cycle (back-to-back).
  task automatic wait_done(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.done) return;
    end
    check({name, "_timeout"}, 32'(bus.done), 32'd1);
  endtask

  task automatic run(input string name, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input logic [31:0] hi,
                     input logic [31:0] lo, input int lat);
    issue(name, op, a, b, res, hi, lo, lat);
    wait_done(name);
  endtask

  initial begin
    vectors            = 0;
    miscompares        = 0;
    cyc                = 0;
    rst_n              = 1'b0;
    bus.start          = 1'b0;
    bus.entradaA       = '0;
    bus.entradaB       = '0;
    bus.entradaControl = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_res",  bus.ALUresult, 32'd0);
    check("rst_zero", 32'(bus.Zero), 32'd1);
    check("rst_hi",   bus.HI,        32'd0);
    check("rst_lo",   bus.LO,        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-cycle ops, A=3 B=2, HI/LO still 0
    run("add",     4'd2,  32'd3, 32'd2, 32'd5,          32'd0, 32'd0, 1);
    run("sub",     4'd6,  32'd3, 32'd2, 32'd1,          32'd0, 32'd0, 1);
    run("slt",     4'd7,  32'd3, 32'd2, 32'd0,          32'd0, 32'd0, 1);
    run("and",     4'd0,  32'd3, 32'd2, 32'd2,          32'd0, 32'd0, 1);
    run("or",      4'd1,  32'd3, 32'd2, 32'd3,          32'd0, 32'd0, 1);
    run("nor",     4'd12, 32'd3, 32'd2, 32'hFFFF_FFFC,  32'd0, 32'd0, 1);
    run("sub_eq",  4'd6,  32'd2, 32'd2, 32'd0,          32'd0, 32'd0, 1);
    run("slt_neg", 4'd7,  32'hFFFF_FFFF, 32'd1, 32'd1,  32'd0, 32'd0, 1);
    run("add_wrap",4'd2,  32'hFFFF_FFFF, 32'd2, 32'd1,  32'd0, 32'd0, 1);
    run("illegal", 4'd3,  32'd3, 32'd2, 32'd0,          32'd0, 32'd0, 1);

    // Unsigned multiply and readback
    run("multu",   4'd8,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFE, 33);
    run("mfhi",    4'd13, 32'd0, 32'd0, 32'd1,          32'd1, 32'hFFFF_FFFE, 1);
    run("mflo",    4'd14, 32'd0, 32'd0, 32'hFFFF_FFFE,  32'd1, 32'hFFFF_FFFE, 1);
    run("add_keep",4'd2,  32'd3, 32'd2, 32'd5,          32'd1, 32'hFFFF_FFFE, 1);

    // Unsigned divide, including divide by zero
    run("divu",    4'd9,  32'd7, 32'd2, 32'd3,          32'd1, 32'd3, 33);
    run("divu_z",  4'd9,  32'd7, 32'd0, 32'hFFFF_FFFF,  32'd7, 32'hFFFF_FFFF, 2);
    run("mfhi_z",  4'd13, 32'd0, 32'd0, 32'd7,          32'd7, 32'hFFFF_FFFF, 1);
    run("divu_max",4'd9,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1, 33);
    run("multu_0", 4'd8,  32'd0, 32'd5, 32'd0,          32'd0, 32'd0, 33);
    run("divu_100",4'd9,  32'd100, 32'd7, 32'd14,       32'd2, 32'd14, 33);

`ifdef MULDIV_SIGNED_EN
    run("mult_n",  4'd10, 32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 33);
    run("mult_nn", 4'd10, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd6, 32'd0, 32'd6, 33);
    run("div_n",   4'd11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run("div_pn",  4'd11, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFFD, 33);
    run("div_z",   4'd11, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 2);
`else
    run("op10",    4'd10, 32'd3, 32'd2, 32'd0,          32'd2, 32'd14, 1);
    run("op11",    4'd11, 32'd7, 32'd2, 32'd0,          32'd2, 32'd14, 1);
`endif

    // Launch from a quiet IDLE, then a start while busy must be ignored
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);
    issue("multu_ign", 4'd8, 32'h1234_5678, 32'h10, 32'h2345_6780, 32'd1, 32'h2345_6780, 33);
    repeat (8) @(negedge clk);
    bus.entradaControl = 4'd9;
    bus.entradaA       = 32'd7;
    bus.entradaB       = 32'd0;
    bus.start          = 1'b1;
    check("busy_inflight", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("multu_ign");

    // Reset in the middle of a multiply aborts it
    issue("multu_abort", 4'd8, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFE, 33);
    repeat (18) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_hi",   bus.HI,        32'd0);
    check("abort_lo",   bus.LO,        32'd0);
    check("abort_res",  bus.ALUresult, 32'd0);
    check("abort_zero", 32'(bus.Zero), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_quiet", 32'(bus.done), 32'd0);
    run("add_post",  4'd2,  32'd3, 32'd2, 32'd5, 32'd0, 32'd0, 1);
    run("mflo_post", 4'd14, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1);

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
